// File: rtl/demux_sequencer.sv
// Purpose: one-word skid register that steers each accepted word to one of n channels (addressed or round-robin).
// Latency: 1 cycle from accept edge to outValid; sustains 1 word/cycle when the selected channel is ready.
// Backpressure: inReady follows outReady of the held word's channel; held word is frozen while that channel stalls.
module demux_sequencer #(
  parameter int n         = 4,
  parameter int logn      = $clog2(n),
  parameter int dataWidth = 8
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [dataWidth-1:0] inData,
  input  logic [logn-1:0]      inDest,
  input  logic                 rrMode,
  output logic [n-1:0]         outValid,
  input  logic [n-1:0]         outReady,
  output logic [dataWidth-1:0] outData,
  output logic [logn-1:0]      sel,
  output logic                 errDrop
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  // Channel count widened by one bit so an out-of-range dest can be detected for non-power-of-2 n.
  localparam logic [logn:0]   nch    = (logn+1)'(n);
  localparam logic [logn-1:0] lastch = logn'(n-1);

  state_t                 state, state_nxt;
  logic [logn-1:0]        sel_q;
  logic [logn-1:0]        rr_ptr;
  logic [logn-1:0]        target;
  logic [dataWidth-1:0]   data_q;
  logic                   drop_q;
  logic [n-1:0]           onehot;
  logic                   sel_rdy;
  logic                   accept;
  logic                   transfer;
  logic                   drop;
  logic                   load;

  // Decode the held channel into a one-hot vector; sel_q is always < n once loaded.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < n; i++) begin
      if (sel_q == i[logn-1:0]) onehot[i] = 1'b1;
    end
  end

  // Only the selected channel's ready bit matters; the others are masked off.
  assign sel_rdy  = |(outReady & onehot);
  assign inReady  = (state == EMPTY) ? 1'b1 : sel_rdy;
  assign accept   = inValid && inReady;
  assign transfer = (state == FULL) && sel_rdy;
  assign target   = rrMode ? rr_ptr : inDest;
  // Out-of-range dest: the word is consumed upstream but never loaded.
  assign drop     = accept && !rrMode && ({1'b0, inDest} >= nch);
  assign load     = accept && !drop;

  assign outValid = (state == FULL) ? onehot : '0;
  assign outData  = data_q;
  assign sel      = ((state == EMPTY) && rrMode) ? rr_ptr : sel_q;
  assign errDrop  = drop_q;

  // State register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Next state: a load always leaves us FULL; a transfer with no load empties the slot.
  // A drop while FULL coincides with a transfer (accept needs the held word to leave), so it empties.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (load) state_nxt = FULL;
      FULL:    if (load) state_nxt = FULL;
               else if (transfer) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Held word, its channel, the round-robin pointer and the drop pulse.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      data_q <= '0;
      sel_q  <= '0;
      rr_ptr <= '0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop;
      if (load) begin
        data_q <= inData;
        sel_q  <= target;
      end
      if (accept && rrMode) rr_ptr <= (rr_ptr == lastch) ? '0 : rr_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_sequencer.sv
// Purpose: directed bench for demux_sequencer, n=4 main instance plus n=3 instance for drop handling.
// Latency: checks are sampled 1 time unit after each rising edge.
// Backpressure: exercised by stalling the held channel while upstream keeps offering words.
module tb_demux_sequencer;

  logic       clk;
  logic       rstN;
  int         checks;
  int         errors;

  // n=4 instance
  logic       inValid, inReady, rrMode, errDrop;
  logic [7:0] inData, outData;
  logic [1:0] inDest, sel;
  logic [3:0] outValid, outReady;

  // n=3 instance
  logic       d3_inValid, d3_inReady, d3_rrMode, d3_errDrop;
  logic [7:0] d3_inData, d3_outData;
  logic [1:0] d3_inDest, d3_sel;
  logic [2:0] d3_outValid, d3_outReady;

  demux_sequencer #(.n(4), .dataWidth(8)) u4 (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady), .inData(inData),
    .inDest(inDest), .rrMode(rrMode), .outValid(outValid), .outReady(outReady),
    .outData(outData), .sel(sel), .errDrop(errDrop)
  );

  demux_sequencer #(.n(3), .dataWidth(8)) u3 (
    .clk(clk), .rstN(rstN), .inValid(d3_inValid), .inReady(d3_inReady), .inData(d3_inData),
    .inDest(d3_inDest), .rrMode(d3_rrMode), .outValid(d3_outValid), .outReady(d3_outReady),
    .outData(d3_outData), .sel(d3_sel), .errDrop(d3_errDrop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    inValid = 0; inData = 0; inDest = 0; rrMode = 0; outReady = 0;
    d3_inValid = 0; d3_inData = 0; d3_inDest = 0; d3_rrMode = 0; d3_outReady = 0;
    #3;
    checks++; if (outValid !== 4'b0000) begin errors++; $display("FAIL reset_outValid got %b want 0000", outValid); end
    checks++; if (outData !== 8'h00) begin errors++; $display("FAIL reset_outData got %h want 00", outData); end
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", sel); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady got %b want 1", inReady); end
    checks++; if (errDrop !== 1'b0) begin errors++; $display("FAIL reset_errDrop got %b want 0", errDrop); end
    step();
    step();
    #2 rstN = 1'b1;
    step();
    checks++; if (outValid !== 4'b0000 || inReady !== 1'b1) begin errors++; $display("FAIL post_reset_idle got v=%b r=%b want v=0000 r=1", outValid, inReady); end
  endtask

  task automatic test_addressed();
    rrMode = 0; inValid = 1; inData = 8'hA5; inDest = 2'd2; outReady = 4'b0100;
    #1;
    checks++; if (outValid !== 4'b0000) begin errors++; $display("FAIL addr_pre_outValid got %b want 0000", outValid); end
    step();
    inValid = 0;
    #1;
    checks++; if (outValid !== 4'b0100) begin errors++; $display("FAIL addr_outValid got %b want 0100", outValid); end
    checks++; if (outData !== 8'hA5) begin errors++; $display("FAIL addr_outData got %h want a5", outData); end
    checks++; if (sel !== 2'd2) begin errors++; $display("FAIL addr_sel got %0d want 2", sel); end
    step();
    checks++; if (outValid !== 4'b0000) begin errors++; $display("FAIL addr_empty got %b want 0000", outValid); end
  endtask

  task automatic test_rr();
    logic [3:0] exp_v;
    rrMode = 1; outReady = 4'hF; inValid = 1; inData = 8'h01;
    #1;
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL rr_empty_sel got %0d want 0", sel); end
    for (int k = 1; k <= 5; k++) begin
      step();
      exp_v = 4'b0001 << ((k - 1) % 4);
      checks++; if (outValid !== exp_v) begin errors++; $display("FAIL rr_outValid[%0d] got %b want %b", k, outValid, exp_v); end
      checks++; if (outData !== 8'(k)) begin errors++; $display("FAIL rr_outData[%0d] got %h want %h", k, outData, 8'(k)); end
      checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL rr_inReady[%0d] got %b want 1", k, inReady); end
      inData = 8'(k + 1);
      if (k == 5) inValid = 0;
    end
    step();
    checks++; if (outValid !== 4'b0000) begin errors++; $display("FAIL rr_drain got %b want 0000", outValid); end
    checks++; if (sel !== 2'd1) begin errors++; $display("FAIL rr_wrap_ptr got %0d want 1", sel); end
  endtask

  task automatic test_backpressure();
    rrMode = 0; inValid = 1; inData = 8'h11; inDest = 2'd1; outReady = 4'b1101;
    step();
    inData = 8'h22; inDest = 2'd3;
    for (int c = 0; c < 3; c++) begin
      rrMode = (c == 1);
      #1;
      checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL bp_inReady[%0d] got %b want 0", c, inReady); end
      checks++; if (outValid !== 4'b0010) begin errors++; $display("FAIL bp_outValid[%0d] got %b want 0010", c, outValid); end
      checks++; if (outData !== 8'h11) begin errors++; $display("FAIL bp_outData[%0d] got %h want 11", c, outData); end
      checks++; if (sel !== 2'd1) begin errors++; $display("FAIL bp_sel[%0d] got %0d want 1", c, sel); end
      step();
    end
    rrMode = 0; outReady = 4'b0010;
    #1;
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL bp_release_inReady got %b want 1", inReady); end
    step();
    inValid = 0; outReady = 4'hF;
    #1;
    checks++; if (outValid !== 4'b1000) begin errors++; $display("FAIL bp_new_outValid got %b want 1000", outValid); end
    checks++; if (outData !== 8'h22) begin errors++; $display("FAIL bp_new_outData got %h want 22", outData); end
    step();
    checks++; if (outValid !== 4'b0000) begin errors++; $display("FAIL bp_drain got %b want 0000", outValid); end
  endtask

  task automatic test_drop();
    d3_rrMode = 0; d3_inValid = 1; d3_inData = 8'h77; d3_inDest = 2'd3; d3_outReady = 3'b111;
    #1;
    checks++; if (d3_inReady !== 1'b1) begin errors++; $display("FAIL drop_inReady got %b want 1", d3_inReady); end
    step();
    d3_inValid = 0;
    #1;
    checks++; if (d3_errDrop !== 1'b1) begin errors++; $display("FAIL drop_pulse got %b want 1", d3_errDrop); end
    checks++; if (d3_outValid !== 3'b000) begin errors++; $display("FAIL drop_outValid got %b want 000", d3_outValid); end
    step();
    checks++; if (d3_errDrop !== 1'b0) begin errors++; $display("FAIL drop_pulse_end got %b want 0", d3_errDrop); end
    checks++; if (d3_outValid !== 3'b000) begin errors++; $display("FAIL drop_outValid2 got %b want 000", d3_outValid); end
    d3_inValid = 1; d3_inData = 8'h88; d3_inDest = 2'd2; d3_outReady = 3'b000;
    step();
    d3_inValid = 0;
    #1;
    checks++; if (d3_outValid !== 3'b100 || d3_outData !== 8'h88) begin errors++; $display("FAIL drop_valid_dest got v=%b d=%h want v=100 d=88", d3_outValid, d3_outData); end
    checks++; if (d3_errDrop !== 1'b0) begin errors++; $display("FAIL drop_no_pulse got %b want 0", d3_errDrop); end
  endtask

  task automatic test_reset_mid();
    rrMode = 0; inValid = 1; inData = 8'h5A; inDest = 2'd2; outReady = 4'b0000;
    step();
    inValid = 0;
    #1;
    checks++; if (outValid !== 4'b0100) begin errors++; $display("FAIL rst_mid_full got %b want 0100", outValid); end
    #1 rstN = 1'b0;
    #1;
    checks++; if (outValid !== 4'b0000) begin errors++; $display("FAIL rst_mid_async_outValid got %b want 0000", outValid); end
    checks++; if (outData !== 8'h00 || sel !== 2'd0) begin errors++; $display("FAIL rst_mid_async_regs got d=%h s=%0d want d=00 s=0", outData, sel); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL rst_mid_inReady got %b want 1", inReady); end
    #1 rstN = 1'b1;
    outReady = 4'hF;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (outValid !== 4'b0000) begin errors++; $display("FAIL rst_mid_no_delivery[%0d] got %b want 0000", c, outValid); end
    end
    rrMode = 1; inValid = 1; inData = 8'h99;
    #1;
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL rst_mid_rr_ptr got %0d want 0", sel); end
    step();
    inValid = 0;
    #1;
    checks++; if (outValid !== 4'b0001 || outData !== 8'h99) begin errors++; $display("FAIL rst_mid_rr_first got v=%b d=%h want v=0001 d=99", outValid, outData); end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_addressed();
    test_rr();
    test_backpressure();
    test_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_sequencer.md
DEMUX_SEQUENCER -- requirements
Module: demux_sequencer

Interface
REQ-001 SHALL have parameter n, default 4: number of output channels, n >= 2.
REQ-002 SHALL have parameter logn, default $clog2(n): channel-select width.
REQ-003 SHALL have parameter dataWidth, default 8: word width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rstN  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port inValid  input  1  upstream word present.
REQ-007 SHALL have port inReady  output  1  block accepts word this cycle.
REQ-008 SHALL have port inData  input  dataWidth  upstream word.
REQ-009 SHALL have port inDest  input  logn  destination channel, used when rrMode=0.
REQ-010 SHALL have port rrMode  input  1  1 = round-robin distribution, 0 = addressed.
REQ-011 SHALL have port outValid  output  n  one-hot word-present per channel.
REQ-012 SHALL have port outReady  input  n  per-channel downstream ready.
REQ-013 SHALL have port outData  output  dataWidth  held word, shared by all channels.
REQ-014 SHALL have port sel  output  logn  channel of held word (or next RR target when empty).
REQ-015 SHALL have port errDrop  output  1  one-cycle pulse: word dropped for out-of-range dest.

Function
REQ-016 SHALL implement FSM with states EMPTY (no held word) and FULL (one held word).
REQ-017 SHALL define accept as inValid && inReady at a rising edge; transfer as FULL && outReady[sel] at a rising edge.
REQ-018 SHALL drive inReady = 1 in EMPTY and inReady = outReady[sel] in FULL (no combinational path from inValid to inReady).
REQ-019 SHALL, on accept, register inData into outData and target into sel, entering/remaining FULL; latency accept-edge to outValid high = 1 cycle.
REQ-020 SHALL, in addressed mode, use target = inDest; in RR mode, target = RR pointer.
REQ-021 SHALL advance the RR pointer by 1 on each accept made in RR mode, wrapping n-1 -> 0; pointer unchanged in addressed mode.
REQ-022 SHALL drive outValid = one-hot of sel when FULL, all zero when EMPTY; no two bits high ever.
REQ-023 SHALL, on transfer without simultaneous accept, return to EMPTY.
REQ-024 SHALL, on simultaneous transfer and accept, stay FULL with new word; sustained throughput 1 word/cycle.
REQ-025 SHALL hold outData, sel, outValid stable while FULL and outReady[sel]=0 (backpressure), regardless of inValid, inDest, rrMode changes.
REQ-026 SHALL ignore outReady bits of non-selected channels.
REQ-027 SHALL, in addressed mode with inDest >= n (non-power-of-2 n), consume the word (accept occurs), not load it, pulse errDrop for one cycle, leave FSM state and held word unchanged.
REQ-028 SHALL sample rrMode only at accept; a mode change never alters a held word's channel.
REQ-029 SHALL drive sel = RR pointer in EMPTY when rrMode=1, last loaded value when rrMode=0.

Reset
REQ-030 SHALL, on rstN low, immediately (asynchronously) force state EMPTY, outValid = 0, outData = 0, sel = 0, RR pointer = 0, errDrop = 0.
REQ-031 SHALL discard any held word on reset mid-operation; no delivery after reset release without a new accept.
REQ-032 SHALL drive inReady = 1 during and after reset (EMPTY).

Verification
REQ-033 SHALL verify addressed: n=4, rrMode=0, word 0xA5 dest 2, outReady=4'b0100 -> outValid=4'b0100 one cycle after accept, outData=0xA5, transfer next edge, EMPTY.
REQ-034 SHALL verify RR: rrMode=1, 5 back-to-back words 0x01..0x05, outReady=4'hF -> channels 0,1,2,3,0 in order, 1 word/cycle, inReady stays 1.
REQ-035 SHALL verify backpressure: FULL on ch1, outReady=4'b1101 for 3 cycles with inValid=1 -> inReady=0, outData/sel/outValid unchanged; ch1 ready -> transfer and new word accepted same edge.
REQ-036 SHALL verify drop: n=3, rrMode=0, inDest=3 -> word consumed, errDrop high exactly 1 cycle, outValid stays 0.
REQ-037 SHALL verify reset mid-operation: FULL on ch2, rstN low between edges -> outValid=0 without clock edge; after release, no output until new accept, RR restarts at ch0.
